// File: rtl/avmm_csr_bridge_pkg.sv
// Shared types and helpers for the Avalon-MM to CSR bridge.
// Optional macro AVMM_CSR_BRIDGE_RMW_EN adds the read-modify-write state.
package avmm_csr_bridge_pkg;

  localparam int DEFAULT_ADDR_W  = 8;
  localparam int DEFAULT_DATA_W  = 32;
  localparam int MERGE_MAX_W     = 256;
  localparam int MERGE_MAX_LANES = MERGE_MAX_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD      = 3'd2,
    ST_RD_WAIT = 3'd3,
`ifdef AVMM_CSR_BRIDGE_RMW_EN
    ST_RESP    = 3'd4,
    ST_RMW_WR  = 3'd5
`else
    ST_RESP    = 3'd4
`endif
  } state_t;

  // Callers zero-extend into the widest supported bus and truncate the result back.
  function automatic logic [MERGE_MAX_W-1:0] mergeLanes(
    input logic [MERGE_MAX_W-1:0]     newData,
    input logic [MERGE_MAX_W-1:0]     oldData,
    input logic [MERGE_MAX_LANES-1:0] laneEn
  );
    logic [MERGE_MAX_W-1:0] merged;
    merged = '0;
    for (int i = 0; i < MERGE_MAX_LANES; i++) begin
      merged[i*8 +: 8] = laneEn[i] ? newData[i*8 +: 8] : oldData[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/avmm_csr_bridge.sv
// Avalon-MM slave that converts commands into single-cycle CSR read/write strobes.
// Define AVMM_CSR_BRIDGE_RMW_EN to execute partial writes as read-modify-write.
module avmm_csr_bridge
  import avmm_csr_bridge_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                reg_clk_i,
  input  logic                reg_rst_i,
  input  logic [ADDR_W-1:0]   avs_address_i,
  input  logic                avs_read_i,
  input  logic                avs_write_i,
  input  logic [DATA_W-1:0]   avs_writedata_i,
  input  logic [DATA_W/8-1:0] avs_byteenable_i,
  output logic                avs_waitrequest_o,
  output logic [DATA_W-1:0]   avs_readdata_o,
  output logic                avs_readdatavalid_o,
  output logic [ADDR_W-1:0]   reg_addr_o,
  output logic [DATA_W-1:0]   reg_wr_data_o,
  output logic                reg_wr_en_o,
  output logic                reg_rd_en_o,
  input  logic [DATA_W-1:0]   reg_rd_data_i,
  output logic                proto_err_o
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wrData;
  logic [DATA_W-1:0]   r_rdData;
  logic                r_wrEn;
  logic                r_rdEn;
  logic                r_rdValid;
  logic                r_protoErr;
`ifdef AVMM_CSR_BRIDGE_RMW_EN
  logic [DATA_W/8-1:0] r_be;
  logic                r_isRmw;
`endif

  logic w_accept;
  logic w_beZero;
  logic w_beFull;

  assign w_accept = (r_state == ST_IDLE) && (avs_read_i || avs_write_i);
  assign w_beZero = (avs_byteenable_i == '0);
  assign w_beFull = &avs_byteenable_i;

  // Write wins a simultaneous read/write; the read is dropped and flagged.
  always_ff @(posedge reg_clk_i or posedge reg_rst_i) begin
    if (reg_rst_i) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_wrData   <= '0;
      r_rdData   <= '0;
      r_wrEn     <= 1'b0;
      r_rdEn     <= 1'b0;
      r_rdValid  <= 1'b0;
      r_protoErr <= 1'b0;
`ifdef AVMM_CSR_BRIDGE_RMW_EN
      r_be       <= '0;
      r_isRmw    <= 1'b0;
`endif
    end else begin
      r_wrEn    <= 1'b0;
      r_rdEn    <= 1'b0;
      r_rdValid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr <= avs_address_i;
            if (avs_write_i) begin
              r_wrData <= avs_writedata_i;
              if (avs_read_i) begin
                r_protoErr <= 1'b1;
              end
              if (w_beFull) begin
                r_wrEn  <= 1'b1;
                r_state <= ST_WR;
              end else if (!w_beZero) begin
`ifdef AVMM_CSR_BRIDGE_RMW_EN
                r_be    <= avs_byteenable_i;
                r_isRmw <= 1'b1;
                r_rdEn  <= 1'b1;
                r_state <= ST_RD;
`else
                r_protoErr <= 1'b1;
`endif
              end
            end else begin
`ifdef AVMM_CSR_BRIDGE_RMW_EN
              r_isRmw <= 1'b0;
`endif
              r_rdEn  <= 1'b1;
              r_state <= ST_RD;
            end
          end
        end
        ST_WR:   r_state <= ST_IDLE;
        ST_RD:   r_state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
`ifdef AVMM_CSR_BRIDGE_RMW_EN
          if (r_isRmw) begin
            r_wrData <= DATA_W'(mergeLanes(MERGE_MAX_W'(r_wrData),
                                           MERGE_MAX_W'(reg_rd_data_i),
                                           MERGE_MAX_LANES'(r_be)));
            r_wrEn   <= 1'b1;
            r_state  <= ST_RMW_WR;
          end else
`endif
          begin
            r_rdData  <= reg_rd_data_i;
            r_rdValid <= 1'b1;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
`ifdef AVMM_CSR_BRIDGE_RMW_EN
        ST_RMW_WR: r_state <= ST_IDLE;
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign avs_waitrequest_o   = (r_state != ST_IDLE);
  assign avs_readdata_o      = r_rdData;
  assign avs_readdatavalid_o = r_rdValid;
  assign reg_addr_o          = r_addr;
  assign reg_wr_data_o       = r_wrData;
  assign reg_wr_en_o         = r_wrEn;
  assign reg_rd_en_o         = r_rdEn;
  assign proto_err_o         = r_protoErr;

endmodule

// File: tb/tb_avmm_csr_bridge.sv
// Directed self-checking bench for avmm_csr_bridge with a small CSR slave model.
// Partial-write expectations follow AVMM_CSR_BRIDGE_RMW_EN when it is defined.
module tb_avmm_csr_bridge;

  logic        regClk = 1'b0;
  logic        regRst = 1'b1;
  logic [7:0]  avsAddress;
  logic        avsRead;
  logic        avsWrite;
  logic [31:0] avsWritedata;
  logic [3:0]  avsByteenable;
  logic        avsWaitrequest;
  logic [31:0] avsReaddata;
  logic        avsReaddatavalid;
  logic [7:0]  regAddr;
  logic [31:0] regWrData;
  logic        regWrEn;
  logic        regRdEn;
  logic [31:0] regRdData = 32'hDEAD_BEEF;
  logic        protoErr;

  logic [31:0] csrMem [0:3];
  int checks = 0;
  int errors = 0;
  int wrPulses = 0;
  int rdPulses = 0;
  int validPulses = 0;
  int overlaps = 0;
  int longStrobes = 0;
  logic prevWr = 1'b0;
  logic prevRd = 1'b0;

  avmm_csr_bridge #(.ADDR_W(8), .DATA_W(32)) dut (
    .reg_clk_i          (regClk),
    .reg_rst_i          (regRst),
    .avs_address_i      (avsAddress),
    .avs_read_i         (avsRead),
    .avs_write_i        (avsWrite),
    .avs_writedata_i    (avsWritedata),
    .avs_byteenable_i   (avsByteenable),
    .avs_waitrequest_o  (avsWaitrequest),
    .avs_readdata_o     (avsReaddata),
    .avs_readdatavalid_o(avsReaddatavalid),
    .reg_addr_o         (regAddr),
    .reg_wr_data_o      (regWrData),
    .reg_wr_en_o        (regWrEn),
    .reg_rd_en_o        (regRdEn),
    .reg_rd_data_i      (regRdData),
    .proto_err_o        (protoErr)
  );

  always #5 regClk = ~regClk;

  // Read-only CSR slave: data valid only in the cycle after a read strobe.
  always @(posedge regClk) begin
    regRdData <= regRdEn ? csrMem[regAddr[1:0]] : 32'hDEAD_BEEF;
  end

  always @(negedge regClk) begin
    if (!regRst) begin
      if (regWrEn) wrPulses++;
      if (regRdEn) rdPulses++;
      if (avsReaddatavalid) validPulses++;
      if (regWrEn && regRdEn) overlaps++;
      if ((regWrEn && prevWr) || (regRdEn && prevRd)) longStrobes++;
    end
    prevWr = regWrEn;
    prevRd = regRdEn;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] addr,
                               input logic [31:0] data, input logic [3:0] be);
    avsRead       = rd;
    avsWrite      = wr;
    avsAddress    = addr;
    avsWritedata  = data;
    avsByteenable = be;
  endtask

  task automatic tick();
    @(posedge regClk);
    #1;
  endtask

  initial begin
    int n;
    int expWr;
    int expRd;
    csrMem[0] = 32'h0000_0000;
    csrMem[1] = 32'hC000_8015;
    csrMem[2] = 32'h1234_5678;
    csrMem[3] = 32'h0000_0000;
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    regRst = 1'b1;
    repeat (2) @(posedge regClk);
    #1;
    checkOutput("rstWait",   32'(avsWaitrequest), 32'd0);
    checkOutput("rstWrEn",   32'(regWrEn), 32'd0);
    checkOutput("rstRdEn",   32'(regRdEn), 32'd0);
    checkOutput("rstValid",  32'(avsReaddatavalid), 32'd0);
    checkOutput("rstPerr",   32'(protoErr), 32'd0);
    checkOutput("rstAddr",   32'(regAddr), 32'd0);
    checkOutput("rstWrData", regWrData, 32'd0);
    checkOutput("rstRdData", avsReaddata, 32'd0);
    @(negedge regClk);
    regRst = 1'b0;

    // Full write, then a back-to-back read in the first idle cycle.
    tick();
    applyStimulus(1'b0, 1'b1, 8'h01, 32'h0000_8015, 4'hF);
    checkOutput("wrAcceptWait", 32'(avsWaitrequest), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    checkOutput("wrEn",     32'(regWrEn), 32'd1);
    checkOutput("wrRdEn",   32'(regRdEn), 32'd0);
    checkOutput("wrAddr",   32'(regAddr), 32'h01);
    checkOutput("wrData",   regWrData, 32'h0000_8015);
    checkOutput("wrWait",   32'(avsWaitrequest), 32'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h01, 32'h0, 4'h0);
    checkOutput("rdAcceptWait", 32'(avsWaitrequest), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    checkOutput("rdEnT1",   32'(regRdEn), 32'd1);
    checkOutput("rdWaitT1", 32'(avsWaitrequest), 32'd1);
    tick();
    checkOutput("rdEnT2",    32'(regRdEn), 32'd0);
    checkOutput("rdValidT2", 32'(avsReaddatavalid), 32'd0);
    tick();
    checkOutput("rdValidT3", 32'(avsReaddatavalid), 32'd1);
    checkOutput("rdDataT3",  avsReaddata, 32'hC000_8015);
    tick();
    checkOutput("rdValidT4", 32'(avsReaddatavalid), 32'd0);
    checkOutput("rdHold",    avsReaddata, 32'hC000_8015);
    checkOutput("rdWaitT4",  32'(avsWaitrequest), 32'd0);

    // All-zero byteenable: accepted, no CSR cycle, no error.
    applyStimulus(1'b0, 1'b1, 8'h02, 32'hFFFF_FFFF, 4'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    checkOutput("be0WrEn", 32'(regWrEn), 32'd0);
    checkOutput("be0RdEn", 32'(regRdEn), 32'd0);
    checkOutput("be0Wait", 32'(avsWaitrequest), 32'd0);
    checkOutput("be0Perr", 32'(protoErr), 32'd0);

    // Partial write.
    applyStimulus(1'b0, 1'b1, 8'h02, 32'hAABB_CCDD, 4'b0101);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
`ifdef AVMM_CSR_BRIDGE_RMW_EN
    checkOutput("rmwRdEn", 32'(regRdEn), 32'd1);
    checkOutput("rmwWrEnT1", 32'(regWrEn), 32'd0);
    checkOutput("rmwPerr", 32'(protoErr), 32'd0);
    tick();
    tick();
    checkOutput("rmwWrEnT3", 32'(regWrEn), 32'd1);
    checkOutput("rmwData",   regWrData, 32'h12BB_56DD);
    checkOutput("rmwAddr",   32'(regAddr), 32'h02);
    checkOutput("rmwValid",  32'(avsReaddatavalid), 32'd0);
    tick();
    checkOutput("rmwWaitT4", 32'(avsWaitrequest), 32'd0);
`else
    checkOutput("pwWrEn", 32'(regWrEn), 32'd0);
    checkOutput("pwRdEn", 32'(regRdEn), 32'd0);
    checkOutput("pwPerr", 32'(protoErr), 32'd1);
    checkOutput("pwWait", 32'(avsWaitrequest), 32'd0);
    tick();
    checkOutput("pwPerrHeld", 32'(protoErr), 32'd1);
    checkOutput("pwWrEnT2",   32'(regWrEn), 32'd0);
`endif

    // Read and write together: write runs, read discarded, error flagged.
    applyStimulus(1'b1, 1'b1, 8'h00, 32'h0000_0042, 4'hF);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    checkOutput("bothWrEn",   32'(regWrEn), 32'd1);
    checkOutput("bothRdEn",   32'(regRdEn), 32'd0);
    checkOutput("bothPerr",   32'(protoErr), 32'd1);
    checkOutput("bothWrData", regWrData, 32'h0000_0042);
    checkOutput("bothAddr",   32'(regAddr), 32'h00);
    repeat (4) tick();
    checkOutput("bothValidCnt", validPulses, 32'd1);
    checkOutput("bothPerrHeld", 32'(protoErr), 32'd1);

    // Reset during RD_WAIT of a read aborts it.
    applyStimulus(1'b1, 1'b0, 8'h01, 32'h0, 4'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    tick();
    regRst = 1'b1;
    #1;
    checkOutput("midRstValid",  32'(avsReaddatavalid), 32'd0);
    checkOutput("midRstWait",   32'(avsWaitrequest), 32'd0);
    checkOutput("midRstPerr",   32'(protoErr), 32'd0);
    checkOutput("midRstRdData", avsReaddata, 32'd0);
    checkOutput("midRstAddr",   32'(regAddr), 32'd0);
    checkOutput("midRstWrData", regWrData, 32'd0);
    @(negedge regClk);
    regRst = 1'b0;
    repeat (4) tick();
    checkOutput("abortValidCnt", validPulses, 32'd1);

    applyStimulus(1'b1, 1'b0, 8'h01, 32'h0, 4'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    tick();
    tick();
    checkOutput("postRstValid", 32'(avsReaddatavalid), 32'd1);
    checkOutput("postRstData",  avsReaddata, 32'hC000_8015);
    tick();

    // A write held through waitrequest must be taken once the read completes.
    applyStimulus(1'b1, 1'b0, 8'h01, 32'h0, 4'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 8'h03, 32'h0000_00A5, 4'hF);
    n = 0;
    while (avsWaitrequest && n < 10) begin
      tick();
      n++;
    end
    checkOutput("heldTimeout", 32'(n < 10), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    checkOutput("heldWrEn",   32'(regWrEn), 32'd1);
    checkOutput("heldAddr",   32'(regAddr), 32'h03);
    checkOutput("heldWrData", regWrData, 32'h0000_00A5);
    repeat (3) tick();

`ifdef AVMM_CSR_BRIDGE_RMW_EN
    expWr = 4;
    expRd = 5;
`else
    expWr = 3;
    expRd = 4;
`endif
    checkOutput("wrPulseCnt",  wrPulses, expWr);
    checkOutput("rdPulseCnt",  rdPulses, expRd);
    checkOutput("validCnt",    validPulses, 32'd3);
    checkOutput("strobeOverlap", overlaps, 32'd0);
    checkOutput("strobeLength",  longStrobes, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avmm_csr_bridge.md
AVMM_CSR_BRIDGE -- requirements
Module: avmm_csr_bridge

Interface
REQ-001 Parameter ADDR_W, default 8, CSR word address width.
REQ-002 Parameter DATA_W, default 32, data width; SHALL be a multiple of 8.
REQ-003 reg_clk_i  in  1  clock; all logic on rising edge.
REQ-004 reg_rst_i  in  1  reset, asynchronous, active-high.
REQ-005 avs_address_i  in  ADDR_W  Avalon-MM word address.
REQ-006 avs_read_i / avs_write_i  in  1 each  Avalon-MM read / write command.
REQ-007 avs_writedata_i  in  DATA_W  write data.
REQ-008 avs_byteenable_i  in  DATA_W/8  write byte lanes; ignored on reads.
REQ-009 avs_waitrequest_o  out  1  command stall.
REQ-010 avs_readdata_o  out  DATA_W  read response data.
REQ-011 avs_readdatavalid_o  out  1  one-cycle read response strobe.
REQ-012 reg_addr_o  out  ADDR_W  CSR address, registered, held between accesses.
REQ-013 reg_wr_data_o  out  DATA_W  CSR write data, registered.
REQ-014 reg_wr_en_o / reg_rd_en_o  out  1 each  single-cycle CSR strobes, registered.
REQ-015 reg_rd_data_i  in  DATA_W  CSR read data; valid the cycle after reg_rd_en_o.
REQ-016 proto_err_o  out  1  sticky protocol-error flag.

Function
REQ-017 FSM states: IDLE, WR, RD, RD_WAIT, RESP, RMW_WR.
REQ-018 avs_waitrequest_o SHALL be low only in IDLE; a command present in IDLE (cycle T) is accepted, with address, data, byteenable latched.
REQ-019 Full write (byteenable all ones): IDLE->WR; at T+1 reg_wr_en_o=1 with latched addr/data; IDLE at T+2.
REQ-020 Read: IDLE->RD; at T+1 reg_rd_en_o=1; at T+2 (RD_WAIT) reg_rd_data_i captured; at T+3 (RESP) avs_readdatavalid_o=1 with captured data; IDLE at T+4.
REQ-021 avs_readdata_o SHALL hold its last value when avs_readdatavalid_o is low.
REQ-022 Byteenable all zero on write: command accepted, no CSR cycle, stay IDLE.
REQ-023 avs_read_i and avs_write_i both high in IDLE: write executed, read discarded, proto_err_o set.
REQ-024 reg_wr_en_o and reg_rd_en_o SHALL never be high in the same cycle and SHALL each last exactly one cycle.
REQ-025 Back-to-back commands: next command accepted in the first cycle after return to IDLE; no command lost while waitrequest is high.
REQ-026 proto_err_o, once set, SHALL remain high until reset.

Reset
REQ-027 Reset asserted: state IDLE; reg_wr_en_o, reg_rd_en_o, avs_readdatavalid_o, proto_err_o=0; reg_addr_o, reg_wr_data_o, avs_readdata_o=0; avs_waitrequest_o low.
REQ-028 Reset mid-transaction SHALL abort it: no CSR strobe and no readdatavalid issued afterwards for that command.

Configuration
REQ-029 Macro AVMM_CSR_BRIDGE_RMW_EN.
REQ-030 Defined: partial write (byteenable neither all zero nor all ones) SHALL run RD, RD_WAIT, then RMW_WR at T+3 with reg_wr_en_o=1 and data = enabled lanes from writedata, other lanes from captured read data; IDLE at T+4; no readdatavalid issued.
REQ-031 Defined: the RMW read triggers any clear-on-read side effects at that address; this is accepted behaviour.
REQ-032 Not defined: partial write SHALL be accepted, dropped (no CSR cycle), and set proto_err_o; state RMW_WR absent.

Structure
REQ-033 Package avmm_csr_bridge_pkg SHALL hold the FSM state enum, default width constants, and the byte-lane merge function.
REQ-034 No sub-module; single module.

Verification
REQ-035 Write addr 8'h01 data 32'h0000_8015 be 4'hF -> reg_wr_en_o pulse at T+1 with addr 8'h01, data 32'h0000_8015; waitrequest high at T+1.
REQ-036 Read addr 8'h01, reg_rd_data_i=32'hC000_8015 at T+2 -> readdatavalid at T+3 with 32'hC000_8015; reg_rd_en_o only at T+1.
REQ-037 RMW_EN defined, CSR holds 32'h1234_5678, write 32'hAABB_CCDD be 4'b0101 -> CSR write at T+3 with 32'h12BB_56DD, no readdatavalid.
REQ-038 RMW_EN undefined, same partial write -> no reg_wr_en_o, proto_err_o=1 at T+1 and held.
REQ-039 Read and write high together on addr 8'h00 -> only reg_wr_en_o pulses, no readdatavalid, proto_err_o=1.
REQ-040 Reset pulsed at T+2 of a read -> no readdatavalid afterwards; outputs at REQ-027 values; next read completes normally.
